uart_imem_loader: RTL

Controller that sequences the UART program-load path of the CPU top level.
- Takes received bytes from the UART receiver and assembles them LSB-first into 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU in reset while loading and releases it when the load completes.
- Sits between the UART RX byte receiver, the IMEM write port and the CPU core reset.

---
 rtl/loader_pkg.sv | 19 +
 rtl/idle_timer.sv | 37 +++
 rtl/uart_imem_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// State encoding, error codes and the instruction word width.
package loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWrite,
      StRun,
      StErr
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_PARTIAL  = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;

   localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/idle_timer.sv
// Saturating idle counter: counts enabled cycles since the last clear and
// holds at TIMEOUT_CYCLES-1, where the terminal-count output is raised.
module idle_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TermCnt);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_imem_loader.sv
// Sequences a UART program load: packs RX bytes LSB-first into words, writes
// them to IMEM at consecutive addresses and holds the CPU in reset until done.
module uart_imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W         = 14,
   parameter int unsigned IMEM_WORDS     = 16384,
   parameter int unsigned TIMEOUT_CYCLES = 500000
) (
   input  logic                fpga_clk,
   input  logic                reset_n,
   input  logic                rx_valid,
   input  logic [7:0]          rx_byte,
   input  logic                load_start,
   input  logic                run_req,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [WORD_W-1:0]   imem_wdata,
   output logic                cpu_rst_n,
   output logic                load_busy,
   output logic                load_done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [ADDR_W:0]     word_count
);

   localparam logic [ADDR_W:0] MaxWords = (ADDR_W + 1)'(IMEM_WORDS);
   localparam logic [ADDR_W:0] OneWord  = (ADDR_W + 1)'(1);

   state_e              state_q, state_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [23:0]         asm_q, asm_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic [ADDR_W:0]     word_count_q, word_count_d;
   logic [1:0]          err_code_q, err_code_d;

   logic busy;
   logic timer_clr;
   logic timer_tc;

   assign busy      = (state_q == StLoad) || (state_q == StWrite);
   assign timer_clr = load_start || (busy && rx_valid) || !busy;

   idle_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk_i (fpga_clk),
      .rst_ni(reset_n),
      .clr_i (timer_clr),
      .en_i  (busy),
      .tc_o  (timer_tc)
   );

   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      asm_d        = asm_q;
      wdata_d      = wdata_q;
      word_count_d = word_count_q;
      err_code_d   = err_code_q;
      load_done    = 1'b0;

      if (load_start) begin
         state_d      = StLoad;
         byte_idx_d   = 2'd0;
         asm_d        = '0;
         word_count_d = '0;
         err_code_d   = ERR_NONE;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (run_req) state_d = StRun;
            end
            StLoad, StWrite: begin
               // The write-data register is separate, so a byte in WRITE lands in lane 0.
               if (state_q == StWrite) begin
                  word_count_d = word_count_q + OneWord;
                  state_d      = StLoad;
               end
               if (rx_valid) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  unique case (byte_idx_q)
                     2'd0: asm_d[7:0]   = rx_byte;
                     2'd1: asm_d[15:8]  = rx_byte;
                     2'd2: asm_d[23:16] = rx_byte;
                     default: begin
                        if (word_count_q == MaxWords) begin
                           state_d    = StErr;
                           err_code_d = ERR_OVERFLOW;
                        end else begin
                           wdata_d = {rx_byte, asm_q};
                           state_d = StWrite;
                        end
                     end
                  endcase
               end else if (timer_tc) begin
                  // With nothing received yet the timer saturates and LOAD waits.
                  if (byte_idx_q != 2'd0) begin
                     state_d    = StErr;
                     err_code_d = ERR_PARTIAL;
                  end else if (word_count_d != '0) begin
                     state_d   = StRun;
                     load_done = 1'b1;
                  end
               end
            end
            StRun, StErr: begin
               state_d = state_q;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge fpga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         byte_idx_q   <= 2'd0;
         asm_q        <= '0;
         wdata_q      <= '0;
         word_count_q <= '0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         asm_q        <= asm_d;
         wdata_q      <= wdata_d;
         word_count_q <= word_count_d;
         err_code_q   <= err_code_d;
      end
   end

   assign imem_we    = (state_q == StWrite);
   assign imem_addr  = word_count_q[ADDR_W-1:0];
   assign imem_wdata = wdata_q;
   assign cpu_rst_n  = (state_q == StRun);
   assign load_busy  = busy;
   assign err        = (state_q == StErr);
   assign err_code   = err_code_q;
   assign word_count = word_count_q;

endmodule
